// File: rtl/rv32i_core_pkg.sv
// Shared constants for the rv32i core register file and its busy scoreboard.
//   XLEN            architectural data width
//   NR_READ_DEF     default number of register file read ports
//   NR_WRITE_DEF    default number of register file write ports
//   RF_DEPTH_DEF    default number of architectural registers
//   ZERO_REG_INDEX  index of the hard-wired zero register
//   rf_busy_t       busy vector for a default-depth register file
package rv32i_core_pkg;

  localparam int XLEN           = 32;
  localparam int NR_READ_DEF    = 2;
  localparam int NR_WRITE_DEF   = 1;
  localparam int RF_DEPTH_DEF   = 32;
  localparam int ZERO_REG_INDEX = 0;

  typedef logic [RF_DEPTH_DEF-1:0] rf_busy_t;

endpackage

// File: rtl/rv32i_rf_scoreboard.sv
// Per-register busy scoreboard: tracks registers with an in-flight producer.
//   clk_i, rst_ni     clock, async active-low reset
//   clr_valid_i       per write port: qualified write (clears busy of clr_addr)
//   clr_addr_i        per write port: written register
//   alloc_valid_i     mark alloc_addr_i busy (x0 / out-of-range ignored)
//   alloc_addr_i      register receiving a new producer
//   flush_i           clear every busy bit
//   busy_o            busy vector, one bit per register
//   busy_count_o      number of busy registers
module rv32i_rf_scoreboard
  import rv32i_core_pkg::*;
#(
  parameter int DEPTH_P      = RF_DEPTH_DEF,
  parameter int ADDR_WIDTH_P = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1,
  parameter int NR_WRITE_P   = NR_WRITE_DEF,
  parameter int CNT_WIDTH_P  = $clog2(DEPTH_P + 1)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NR_WRITE_P-1:0]              clr_valid_i,
  input  logic [NR_WRITE_P*ADDR_WIDTH_P-1:0] clr_addr_i,
  input  logic                               alloc_valid_i,
  input  logic [ADDR_WIDTH_P-1:0]            alloc_addr_i,
  input  logic                               flush_i,
  output logic [DEPTH_P-1:0]                 busy_o,
  output logic [CNT_WIDTH_P-1:0]             busy_count_o
);

  logic [DEPTH_P-1:0]     r_busy;
  logic [DEPTH_P-1:0]     w_busy_nxt;
  logic [CNT_WIDTH_P-1:0] w_count;

  // Priority (lowest first, later assignments override): write clear,
  // alloc set, flush. Only indices 1..DEPTH_P-1 are decoded, so x0 and
  // out-of-range addresses never touch the vector.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int j = 0; j < NR_WRITE_P; j++) begin
      for (int r = 1; r < DEPTH_P; r++) begin
        if (clr_valid_i[j] && (clr_addr_i[j*ADDR_WIDTH_P +: ADDR_WIDTH_P] == ADDR_WIDTH_P'(r)))
          w_busy_nxt[r] = 1'b0;
      end
    end
    for (int r = 1; r < DEPTH_P; r++) begin
      if (alloc_valid_i && (alloc_addr_i == ADDR_WIDTH_P'(r)))
        w_busy_nxt[r] = 1'b1;
    end
    if (flush_i)
      w_busy_nxt = '0;
    w_busy_nxt[ZERO_REG_INDEX] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      r_busy <= '0;
    else
      r_busy <= w_busy_nxt;
  end

  always_comb begin
    w_count = '0;
    for (int r = 0; r < DEPTH_P; r++)
      w_count = w_count + {{(CNT_WIDTH_P-1){1'b0}}, r_busy[r]};
  end

  assign busy_o       = r_busy;
  assign busy_count_o = w_count;

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (r_busy[ZERO_REG_INDEX] == 1'b0)
        else $error("scoreboard: x0 marked busy");
      assert (busy_count_o <= CNT_WIDTH_P'(DEPTH_P - 1))
        else $error("scoreboard: busy count %0d out of range", busy_count_o);
    end
  end
`endif

endmodule

// File: rtl/rv32i_mp_register_file.sv
// Multi-port register file with integrated busy scoreboard.
//   clk_i, rst_ni   clock, async active-low reset
//   raddr_i         read addresses, port k in slice k
//   rdata_o         read data, port k in slice k (combinational)
//   rready_o        1 = read data is final (no pending writeback)
//   we_i            write enables, one per write port
//   waddr_i         write addresses, port j in slice j
//   wdata_i         write data, port j in slice j
//   alloc_valid_i   mark alloc_addr_i busy
//   alloc_addr_i    register receiving a new in-flight producer
//   flush_i         clear all busy bits
//   busy_count_o    number of busy registers
module rv32i_mp_register_file
  import rv32i_core_pkg::*;
#(
  parameter int XLEN_P       = XLEN,
  parameter int DEPTH_P      = 32,
  parameter int ADDR_WIDTH_P = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1,
  parameter int NR_READ_P    = NR_READ_DEF,
  parameter int NR_WRITE_P   = NR_WRITE_DEF,
  parameter int CNT_WIDTH_P  = $clog2(DEPTH_P + 1)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NR_READ_P*ADDR_WIDTH_P-1:0]  raddr_i,
  output logic [NR_READ_P*XLEN_P-1:0]        rdata_o,
  output logic [NR_READ_P-1:0]               rready_o,
  input  logic [NR_WRITE_P-1:0]              we_i,
  input  logic [NR_WRITE_P*ADDR_WIDTH_P-1:0] waddr_i,
  input  logic [NR_WRITE_P*XLEN_P-1:0]       wdata_i,
  input  logic                               alloc_valid_i,
  input  logic [ADDR_WIDTH_P-1:0]            alloc_addr_i,
  input  logic                               flush_i,
  output logic [CNT_WIDTH_P-1:0]             busy_count_o
);

  localparam logic [ADDR_WIDTH_P:0]   DEPTH_C = (ADDR_WIDTH_P + 1)'(DEPTH_P);
  localparam logic [ADDR_WIDTH_P-1:0] ZERO_A  = ADDR_WIDTH_P'(ZERO_REG_INDEX);

  function automatic logic addr_ok(input logic [ADDR_WIDTH_P-1:0] a);
    return (a != ZERO_A) && ({1'b0, a} < DEPTH_C);
  endfunction

  logic [XLEN_P-1:0]       r_regs [DEPTH_P];
  logic [NR_WRITE_P-1:0]   w_wvalid;
  logic [DEPTH_P-1:0]      w_busy;
  logic [ADDR_WIDTH_P-1:0] w_raddr;
  logic [XLEN_P-1:0]       w_rd;
  logic                    w_rr;
  logic                    w_hit;

  always_comb begin
    for (int j = 0; j < NR_WRITE_P; j++)
      w_wvalid[j] = we_i[j] && addr_ok(waddr_i[j*ADDR_WIDTH_P +: ADDR_WIDTH_P]);
  end

  // Ports are visited in ascending order so the highest-indexed port's
  // assignment lands last and wins on an address conflict.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < DEPTH_P; r++)
        r_regs[r] <= '0;
    end else begin
      for (int j = 0; j < NR_WRITE_P; j++) begin
        for (int r = 1; r < DEPTH_P; r++) begin
          if (w_wvalid[j] && (waddr_i[j*ADDR_WIDTH_P +: ADDR_WIDTH_P] == ADDR_WIDTH_P'(r)))
            r_regs[r] <= wdata_i[j*XLEN_P +: XLEN_P];
        end
      end
    end
  end

  // Read: zero/out-of-range -> 0 ready; same-cycle write bypass (ready,
  // highest port wins); otherwise stored value, ready unless busy.
  always_comb begin
    rdata_o  = '0;
    rready_o = '1;
    w_raddr  = '0;
    w_rd     = '0;
    w_rr     = 1'b1;
    w_hit    = 1'b0;
    for (int k = 0; k < NR_READ_P; k++) begin
      w_raddr = raddr_i[k*ADDR_WIDTH_P +: ADDR_WIDTH_P];
      w_rd    = '0;
      w_rr    = 1'b1;
      w_hit   = 1'b0;
      if (addr_ok(w_raddr)) begin
        for (int j = 0; j < NR_WRITE_P; j++) begin
          if (w_wvalid[j] && (waddr_i[j*ADDR_WIDTH_P +: ADDR_WIDTH_P] == w_raddr)) begin
            w_rd  = wdata_i[j*XLEN_P +: XLEN_P];
            w_hit = 1'b1;
          end
        end
        if (!w_hit) begin
          for (int r = 1; r < DEPTH_P; r++) begin
            if (w_raddr == ADDR_WIDTH_P'(r)) begin
              w_rd = r_regs[r];
              w_rr = ~w_busy[r];
            end
          end
        end
      end
      rdata_o[k*XLEN_P +: XLEN_P] = w_rd;
      rready_o[k]                 = w_rr;
    end
  end

  rv32i_rf_scoreboard #(
    .DEPTH_P      (DEPTH_P),
    .ADDR_WIDTH_P (ADDR_WIDTH_P),
    .NR_WRITE_P   (NR_WRITE_P),
    .CNT_WIDTH_P  (CNT_WIDTH_P)
  ) u_scoreboard (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clr_valid_i   (w_wvalid),
    .clr_addr_i    (waddr_i),
    .alloc_valid_i (alloc_valid_i),
    .alloc_addr_i  (alloc_addr_i),
    .flush_i       (flush_i),
    .busy_o        (w_busy),
    .busy_count_o  (busy_count_o)
  );

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (r_regs[ZERO_REG_INDEX] == '0)
        else $error("regfile: x0 holds non-zero data");
      assert (!$isunknown(we_i) && !$isunknown(alloc_valid_i))
        else $error("regfile: unknown value on we_i/alloc_valid_i");
      for (int j = 0; j < NR_WRITE_P; j++) begin
        assert (!(we_i[j] && ({1'b0, waddr_i[j*ADDR_WIDTH_P +: ADDR_WIDTH_P]} >= DEPTH_C)))
          else $error("regfile: out-of-range write on port %0d", j);
      end
      assert (!(alloc_valid_i && ({1'b0, alloc_addr_i} >= DEPTH_C)))
        else $error("regfile: out-of-range alloc");
    end
  end
`endif

endmodule

// File: tb/tb_rv32i_mp_register_file.sv
module tb_rv32i_mp_register_file;

  localparam int XL = 32;
  localparam int DP = 16;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int CW = 5;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [NR*AW-1:0]  raddr_i;
  logic [NR*XL-1:0]  rdata_o;
  logic [NR-1:0]     rready_o;
  logic [NW-1:0]     we_i;
  logic [NW*AW-1:0]  waddr_i;
  logic [NW*XL-1:0]  wdata_i;
  logic              alloc_valid_i;
  logic [AW-1:0]     alloc_addr_i;
  logic              flush_i;
  logic [CW-1:0]     busy_count_o;

  rv32i_mp_register_file #(
    .XLEN_P(XL), .DEPTH_P(DP), .ADDR_WIDTH_P(AW),
    .NR_READ_P(NR), .NR_WRITE_P(NW), .CNT_WIDTH_P(CW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .raddr_i(raddr_i), .rdata_o(rdata_o),
    .rready_o(rready_o), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .alloc_valid_i(alloc_valid_i), .alloc_addr_i(alloc_addr_i),
    .flush_i(flush_i), .busy_count_o(busy_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    int          kind;   // 0 rdata, 1 rready, 2 busy_count
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic idle();
    we_i = '0; waddr_i = '0; wdata_i = '0;
    alloc_valid_i = 1'b0; alloc_addr_i = '0; flush_i = 1'b0;
  endtask

  task automatic rd(input int k, input logic [AW-1:0] a);
    raddr_i[k*AW +: AW] = a;
  endtask

  task automatic wr(input int j, input logic [AW-1:0] a, input logic [31:0] d);
    we_i[j] = 1'b1;
    waddr_i[j*AW +: AW] = a;
    wdata_i[j*XL +: XL] = d;
  endtask

  task automatic alloc(input logic [AW-1:0] a);
    alloc_valid_i = 1'b1;
    alloc_addr_i  = a;
  endtask

  task automatic exp_rd(input int k, input logic [31:0] d, input logic r, input string n);
    q.push_back('{name: {n, "_data"}, kind: 0, port: k, exp: d});
    q.push_back('{name: {n, "_rdy"}, kind: 1, port: k, exp: {31'b0, r}});
  endtask

  task automatic exp_cnt(input int c, input string n);
    q.push_back('{name: {n, "_cnt"}, kind: 2, port: 0, exp: 32'(c)});
  endtask

  task automatic check();
    exp_t e;
    logic [31:0] obs;
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.kind)
        0:       obs = rdata_o[e.port*XL +: XL];
        1:       obs = {31'b0, rready_o[e.port]};
        default: obs = {27'b0, busy_count_o};
      endcase
      total++;
      assert (obs === e.exp) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.name, obs, e.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_ni = 1'b0;
    raddr_i = '0;
    idle();
    #2;
    for (int r = 0; r < DP; r++) begin
      rd(0, AW'(r));
      rd(1, AW'(DP - 1 - r));
      exp_rd(0, 32'h0, 1'b1, "rst_p0");
      exp_rd(1, 32'h0, 1'b1, "rst_p1");
      exp_cnt(0, "rst");
      check();
    end
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Write x5, bypass then stored
    wr(0, 5, 32'hDEADBEEF); rd(0, 5); rd(1, 4);
    exp_rd(0, 32'hDEADBEEF, 1'b1, "x5_byp");
    exp_rd(1, 32'h0, 1'b1, "x4_untouched");
    check();
    step();
    exp_rd(0, 32'hDEADBEEF, 1'b1, "x5_store");
    check();

    // Bypass x7 on both ports, x0 write ignored
    wr(0, 7, 32'h11); wr(1, 0, 32'hFFFF_FFFF); rd(0, 7); rd(1, 7);
    exp_rd(0, 32'h11, 1'b1, "x7_byp_p0");
    exp_rd(1, 32'h11, 1'b1, "x7_byp_p1");
    check();
    rd(1, 0);
    exp_rd(1, 32'h0, 1'b1, "x0_byp");
    check();
    step();
    rd(0, 0); rd(1, 7);
    exp_rd(0, 32'h0, 1'b1, "x0_store");
    exp_rd(1, 32'h11, 1'b1, "x7_store");
    check();

    // Conflict: port 1 wins
    wr(0, 3, 32'hAAAA); wr(1, 3, 32'h5555); rd(0, 3);
    exp_rd(0, 32'h5555, 1'b1, "conf_byp");
    check();
    step();
    exp_rd(0, 32'h5555, 1'b1, "conf_store");
    check();

    // Boundary register x15 and first out-of-range index
    wr(1, 15, 32'h1234_5678); rd(0, 15);
    exp_rd(0, 32'h1234_5678, 1'b1, "x15_byp");
    check();
    step();
    rd(1, 16);
    exp_rd(0, 32'h1234_5678, 1'b1, "x15_store");
    exp_rd(1, 32'h0, 1'b1, "oor16");
    check();

    // Alloc x0 ignored
    alloc(0); rd(0, 0);
    step();
    exp_rd(0, 32'h0, 1'b1, "alloc_x0");
    exp_cnt(0, "alloc_x0");
    check();

    // Scoreboard: alloc x9, then writeback
    alloc(9); rd(0, 9);
    exp_rd(0, 32'h0, 1'b1, "alloc_same");
    exp_cnt(0, "alloc_same");
    check();
    step();
    exp_rd(0, 32'h0, 1'b0, "x9_busy");
    exp_cnt(1, "x9_busy");
    check();
    wr(1, 9, 32'h42);
    exp_rd(0, 32'h42, 1'b1, "x9_wb_byp");
    exp_cnt(1, "x9_wb_byp");
    check();
    step();
    exp_rd(0, 32'h42, 1'b1, "x9_done");
    exp_cnt(0, "x9_done");
    check();

    // Alloc beats same-cycle write
    alloc(4); wr(0, 4, 32'h9); rd(0, 4);
    step();
    exp_rd(0, 32'h9, 1'b0, "x4_alloc_wr");
    exp_cnt(1, "x4_alloc_wr");
    check();

    // Flush beats alloc
    flush_i = 1'b1; alloc(6); rd(0, 6); rd(1, 4);
    step();
    exp_rd(0, 32'h0, 1'b1, "x6_flush");
    exp_rd(1, 32'h9, 1'b1, "x4_flush");
    exp_cnt(0, "flush");
    check();

    // Reset mid-operation
    alloc(1);
    step();
    alloc(2); wr(0, 2, 32'h77);
    step();
    alloc(3);
    step();
    rd(0, 2); rd(1, 1);
    exp_rd(0, 32'h77, 1'b0, "pre_rst_x2");
    exp_rd(1, 32'h0, 1'b0, "pre_rst_x1");
    exp_cnt(3, "pre_rst");
    check();
    #1;
    rst_ni = 1'b0;
    exp_rd(0, 32'h0, 1'b1, "rst_x2");
    exp_rd(1, 32'h0, 1'b1, "rst_x1");
    exp_cnt(0, "rst_mid");
    check();
    rd(0, 5); rd(1, 20);
    exp_rd(0, 32'h0, 1'b1, "rst_x5");
    exp_rd(1, 32'h0, 1'b1, "oor20_rst");
    check();
    @(negedge clk_i);
    rst_ni = 1'b1;
    rd(0, 9);
    exp_rd(0, 32'h0, 1'b1, "post_rst_x9");
    exp_rd(1, 32'h0, 1'b1, "oor20");
    exp_cnt(0, "post_rst");
    check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv32i_mp_register_file.md
Name: rv32i_mp_register_file

Overview:
- Multi-port successor to the core's dual-read/single-write register file.
- Generalised in read-port count, write-port count, XLEN and depth.
- Integrates a per-register busy scoreboard so decode can tell whether a source is still awaiting a long-latency writeback (load, mul/div).
- Sits between decode/issue (reads, allocations) and the writeback stage(s) (writes).

Parameters:
- XLEN_P, XLEN (from package), data width.
- DEPTH_P, 32, number of architectural registers; index 0 is hard-wired zero.
- ADDR_WIDTH_P, (DEPTH_P>1)?$clog2(DEPTH_P):1, register address width.
- NR_READ_P, 2, number of asynchronous read ports (1..4).
- NR_WRITE_P, 1, number of synchronous write ports (1..2).
- CNT_WIDTH_P, $clog2(DEPTH_P+1), width of busy count output.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active-low
- raddr_i  in  NR_READ_P*ADDR_WIDTH_P  read addresses; port k in slice k
- rdata_o  out  NR_READ_P*XLEN_P  read data, port k in slice k
- rready_o  out  NR_READ_P  1 = read data valid (not awaiting writeback)
- we_i  in  NR_WRITE_P  write enables
- waddr_i  in  NR_WRITE_P*ADDR_WIDTH_P  write addresses
- wdata_i  in  NR_WRITE_P*XLEN_P  write data
- alloc_valid_i  in  1  mark alloc_addr_i busy (new in-flight producer)
- alloc_addr_i  in  ADDR_WIDTH_P  register to mark busy
- flush_i  in  1  clear all busy bits (pipeline flush)
- busy_count_o  out  CNT_WIDTH_P  number of busy registers

Behaviour:
- Reset (async, rst_ni low): all regs_q = 0, all busy_q = 0. Outputs follow: rdata_o 0 at x0, rready_o all 1, busy_count_o 0.
- Valid write: write port j is valid iff we_i[j] && waddr!=0 && waddr<DEPTH_P. Data commits on the rising clk_i edge.
- Write conflict (two valid ports, same address): the highest-indexed port wins, for both storage and bypass.
- x0: reads return 0 with rready=1. Writes to x0 are ignored. alloc to x0 is ignored; x0 is never busy.
- Out-of-range handling:
  - Read address >= DEPTH_P returns 0 with rready=1.
  - Out-of-range write or alloc is ignored.
  - Sim-only assertion fires on a valid-enable out-of-range address.
- Read path: combinational, zero latency.
  - Priority: zero/out-of-range → bypass from highest-indexed valid write port with matching address (rready=1) → regs_q with rready=!busy_q.
- Busy update per edge, highest priority first:
  1. flush_i: busy_q <= 0 entirely; alloc ignored that cycle; writes still commit data.
  2. alloc_valid_i with valid address: busy_q[alloc_addr] <= 1. This wins over a same-cycle write to the same register: data is written, but the register stays busy because it now has a newer producer.
  3. Any valid write to r clears busy_q[r].
- Same-cycle alloc is not visible to reads; busy shows from the next cycle.
- busy_count_o: popcount of busy_q, combinational from state; range 0..DEPTH_P-1.
- Assertions (not SYNTHESIS):
  - regs_q[0]==0 and busy_q[0]==0 always.
  - busy_count_o <= DEPTH_P-1.
  - No X on we_i/alloc_valid_i out of reset.

Decomposition:
- rv32i_core_pkg:
  - XLEN.
  - Default NR_READ/NR_WRITE constants.
  - ZERO_REG_INDEX constant.
  - Typedef rf_busy_t sized by default depth.
- Sub-module rv32i_rf_scoreboard: holds busy_q, flush/alloc/clear priority logic and popcount.
  - Inputs: per-write-port clear-valid/address, alloc, flush.
  - Outputs: busy vector and busy_count.
- Top level keeps storage, write arbitration and read/bypass muxing.

Test Plan:
- Reset then read all registers on all ports → rdata 0, rready all 1, busy_count 0. Write x5=0xDEADBEEF on port 0 → next cycle reads 0xDEADBEEF.
- Same-cycle bypass and x0:
  - Port0 writes x7=0x11 while reading x7 → rdata 0x11, rready 1 in that cycle.
  - Write x0=0xFFFF_FFFF → x0 reads 0.
- Write conflict (NR_WRITE_P=2): port0 writes x3=0xAAAA, port1 writes x3=0x5555 in the same cycle → bypass and stored value both 0x5555.
- Scoreboard sequence:
  - alloc x9 → next cycle rready for x9 = 0, busy_count 1.
  - Write x9=0x42 → bypass rready 1 that cycle; next cycle busy clear, count 0.
- Alloc/write/flush collisions:
  - alloc x4 and write x4=0x9 in the same cycle → x4 data 0x9, busy stays 1.
  - Then flush_i with alloc x6 → busy_count 0, x6 not busy.
- Reset mid-operation: with x1..x3 busy and x2=0x77, assert rst_ni low asynchronously → immediately count 0, all reads 0/ready. Out-of-range read (DEPTH_P=16, addr 20) → 0, ready 1.
